// File: rtl/dxi_window_gen_if.sv
// -----------------------------------------------------------------------------
// dxi_window_gen_if
//   Handshake bundle for the 3x3 window generator: an upstream pixel stream
//   (valid/ready/8-bit data) and a downstream window stream (valid/ready/72-bit).
//
//   Signals
//     i_dxi_valid      upstream pixel valid
//     i_dxi_data       upstream pixel, raster order
//     o_dxi_ready      generator ready to accept a pixel
//     o_dxi_out_valid  window valid toward the filter
//     o_dxi_out_data   3x3 window, index k at [k*8 +: 8], row-major
//     i_dxi_out_ready  filter ready
//
//   Modports
//     slave   generator side (consumes pixels, produces windows)
//     master  environment side (produces pixels, consumes windows)
// -----------------------------------------------------------------------------
interface dxi_window_gen_if;
   logic        i_dxi_valid;
   logic [7:0]  i_dxi_data;
   logic        o_dxi_ready;
   logic        o_dxi_out_valid;
   logic [71:0] o_dxi_out_data;
   logic        i_dxi_out_ready;

   modport slave (
      input  i_dxi_valid,
      input  i_dxi_data,
      input  i_dxi_out_ready,
      output o_dxi_ready,
      output o_dxi_out_valid,
      output o_dxi_out_data
   );

   modport master (
      output i_dxi_valid,
      output i_dxi_data,
      output i_dxi_out_ready,
      input  o_dxi_ready,
      input  o_dxi_out_valid,
      input  o_dxi_out_data
   );
endinterface

// File: rtl/dxi_window_gen.sv
// -----------------------------------------------------------------------------
// dxi_window_gen
//   Builds a sliding 3x3 pixel window from a raster-order pixel stream using two
//   line buffers (rows r-2 and r-1) and a 3x3 shift register. A window is
//   emitted for every pixel at row >= 2 and column >= 2, so a frame yields
//   (IMG_W-2)*(IMG_H-2) windows with no border padding. Output is registered
//   (one cycle after the bottom-right pixel is accepted) and back-pressure is
//   passed straight through to the pixel input.
//
//   Parameters
//     IMG_W  image width in pixels (3..1024)
//     IMG_H  image height in lines (3..1024)
//
//   Ports
//     i_clk         clock, rising edge
//     i_rst         asynchronous active-high reset
//     i_flush       synchronous frame restart (beats a coincident pixel)
//     dxi           pixel in / window out handshake bundle (slave modport)
//     o_frame_done  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module dxi_window_gen #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   dxi_window_gen_if.slave     dxi,
   output logic                o_frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;

   logic [7:0]      top_buf [IMG_W];
   logic [7:0]      mid_buf [IMG_W];
   logic [7:0]      win_p0  [9];
   logic [7:0]      win_nxt [9];
   logic [71:0]     win_flat;

   logic            out_vld_p1;
   logic [71:0]     out_data_p1;
   logic            frame_done_p1;

   logic            ready;
   logic            acc;
   logic            col_end;
   logic            last_pix;
   logic            emit;

   // A stalled window blocks the input, so the window register never moves
   // underneath a held output.
   assign ready    = !out_vld_p1 || dxi.i_dxi_out_ready;
   assign acc      = dxi.i_dxi_valid && ready && !i_flush;
   assign col_end  = (col == COL_LAST);
   assign last_pix = col_end && (row == ROW_LAST);
   assign emit     = acc && (state == S_RUN) && (col >= CW'(2));

   // Stage 0: shift window left, fill the right column from the line buffers
   always_comb begin
      for (int k = 0; k < 9; k++) begin
         win_nxt[k] = win_p0[k];
      end
      for (int r = 0; r < 3; r++) begin
         win_nxt[r*3]     = win_p0[r*3 + 1];
         win_nxt[r*3 + 1] = win_p0[r*3 + 2];
      end
      win_nxt[2] = top_buf[col];
      win_nxt[5] = mid_buf[col];
      win_nxt[8] = dxi.i_dxi_data;
      win_flat = '0;
      for (int k = 0; k < 9; k++) begin
         win_flat[k*8 +: 8] = win_nxt[k];
      end
   end

   // Line buffers and window taps carry only data; stale contents are never
   // emitted because rows 0 and 1 of each frame rewrite them before use.
   always_ff @(posedge i_clk) begin
      if (acc) begin
         top_buf[col] <= mid_buf[col];
         mid_buf[col] <= dxi.i_dxi_data;
         win_p0       <= win_nxt;
      end
   end

   // Stage 1: counters, FSM and registered window output
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= S_FILL;
         col           <= '0;
         row           <= '0;
         out_vld_p1    <= 1'b0;
         out_data_p1   <= '0;
         frame_done_p1 <= 1'b0;
      end else if (i_flush) begin
         state         <= S_FILL;
         col           <= '0;
         row           <= '0;
         out_vld_p1    <= 1'b0;
         frame_done_p1 <= 1'b0;
      end else begin
         frame_done_p1 <= acc && last_pix;

         if (acc) begin
            if (col_end) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end

            unique case (state)
               S_FILL: if (col_end && (row == RW'(1))) state <= S_RUN;
               S_RUN:  if (last_pix) state <= S_FILL;
               default: state <= S_FILL;
            endcase
         end

         // A new window overwrites the one being handed off in the same cycle.
         if (emit) begin
            out_vld_p1  <= 1'b1;
            out_data_p1 <= win_flat;
         end else if (dxi.i_dxi_out_ready) begin
            out_vld_p1  <= 1'b0;
         end
      end
   end

   assign dxi.o_dxi_ready     = ready;
   assign dxi.o_dxi_out_valid = out_vld_p1;
   assign dxi.o_dxi_out_data  = out_data_p1;
   assign o_frame_done        = frame_done_p1;

endmodule

// File: doc/dxi_window_gen.md
DXI_WINDOW_GEN -- requirements
Module: dxi_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 8, meaning image width in pixels (legal 3..1024).
REQ-002 SHALL have parameter IMG_H, default 8, meaning image height in lines (legal 3..1024).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_flush  input  1  synchronous frame restart.
REQ-006 SHALL have port i_dxi_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port i_dxi_data  input  8  upstream pixel, raster order.
REQ-008 SHALL have port o_dxi_ready  output  1  pixel accepted when valid and ready are both high.
REQ-009 SHALL have port o_dxi_out_valid  output  1  window valid toward filter slave.
REQ-010 SHALL have port o_dxi_out_data  output  72  3x3 window.
REQ-011 SHALL have port i_dxi_out_ready  input  1  filter ready.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 SHALL pack window index k (0..8, row-major, 0 = top-left, 4 = centre) at o_dxi_out_data[k*8 +: 8], the same layout the filter consumes.
REQ-014 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both advancing on each accepted pixel; col wraps to 0 and row increments at col = IMG_W-1.
REQ-015 SHALL wrap row to 0 after the pixel at (IMG_H-1, IMG_W-1), with no idle cycle required before the next frame.
REQ-016 SHALL hold two line buffers of IMG_W bytes: top (row-2) and mid (row-1).
REQ-017 On acceptance at column c, SHALL shift the 3x3 register window one column left.
REQ-018 On acceptance at column c, SHALL load the right column with (top[c], mid[c], pixel).
REQ-019 On acceptance at column c, SHALL write top[c] <= mid[c] and mid[c] <= pixel.
REQ-020 SHALL use FSM states S_FILL (row < 2, no windows emitted) and S_RUN (row >= 2).
REQ-021 SHALL transition S_FILL->S_RUN on acceptance of pixel (1, IMG_W-1).
REQ-022 SHALL transition S_RUN->S_FILL on acceptance of the last pixel of the frame.
REQ-023 SHALL emit a window only for pixels accepted in S_RUN with col >= 2, so each frame emits exactly (IMG_W-2)*(IMG_H-2) windows with no border padding.
REQ-024 SHALL register the window output: o_dxi_out_valid rises the cycle after acceptance of the window's bottom-right pixel (latency 1).
REQ-025 SHALL drive o_dxi_ready = !o_dxi_out_valid || i_dxi_out_ready, combinationally, in both states.
REQ-026 While o_dxi_out_valid && !i_dxi_out_ready, SHALL hold o_dxi_out_data stable and accept no pixel.
REQ-027 On an output handshake with no new window produced in the same cycle, SHALL drop o_dxi_out_valid next cycle.
REQ-028 On simultaneous output handshake and window-producing input acceptance, SHALL load the new window and keep valid high (full throughput: one window per clock).
REQ-029 SHALL pulse o_frame_done high for exactly one cycle, the cycle after acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-030 On i_flush high, SHALL clear col, row, FSM (S_FILL) and o_dxi_out_valid next cycle.
REQ-031 i_flush SHALL take priority over a coincident pixel handshake, which is discarded.
REQ-032 i_flush SHALL NOT pulse o_frame_done.
REQ-033 Line-buffer contents SHALL need no clearing; stale data is never emitted because of the S_FILL rule.

Reset
REQ-034 While i_rst is high, SHALL force o_dxi_out_valid=0, o_dxi_out_data=0, o_frame_done=0, col=0, row=0 and FSM=S_FILL; o_dxi_ready=1 follows combinationally.
REQ-035 SHALL apply reset immediately, without a clock edge, including mid-frame, discarding any pending window.
REQ-036 On release, the first accepted pixel SHALL be treated as (0,0).

Verification
REQ-037 IMG_W=IMG_H=4, pixels 0x00..0x0F, out_ready=1 -> exactly 4 windows; first 72'h0A0908060504020100; second 72'h0B0A09070605030201; last 72'h0F0E0D0B0A09070605; o_frame_done once.
REQ-038 Same stream with out_ready held low 5 cycles after first window -> window 72'h0A0908060504020100 held stable and o_dxi_ready=0 for those cycles; no window lost or duplicated.
REQ-039 Two back-to-back 4x4 frames (0x00..0x0F, then 0x10..0x1F) -> 8 windows total; first window of frame 2 = 72'h1A1918161514121110; two frame_done pulses.
REQ-040 Assert i_rst after pixel 0x09 mid-frame, then replay a full 4x4 frame -> valid low during reset; exactly 4 correct windows afterward, none from pre-reset data.
REQ-041 i_flush coincident with pixel 0x06 handshake, then full 4x4 frame -> 0x06 discarded; no frame_done for the aborted frame; 4 correct windows.
REQ-042 IMG_W=3, IMG_H=3, pixels 0x01..0x09 -> single window 72'h090807060504030201, one frame_done.
